// File: rtl/project_mux_sequencer_pkg.sv
// Shared types and helpers for the project output mux sequencer.
// Holds the FSM state encoding, default slot geometry and counter sizing.
package harness_pkg;

    typedef enum logic [1:0] {
        RUN,
        QUIESCE,
        HOLDRST
    } mux_state_t;

    localparam int unsigned NPROJ_DEF  = 16;
    localparam int unsigned DWIDTH_DEF = 16;

    // Bits needed to hold 0..v-1, never fewer than one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 32'd2) ? 32'd1 : 32'($clog2(v));
    endfunction

endpackage

// File: rtl/project_mux_sequencer_sel_debounce.sv
// Debounces the Wishbone project select: a value is accepted only after it has
// been sampled STABLE_CYC times in a row.
module sel_debounce
    import harness_pkg::*;
#(
    parameter int unsigned SELW       = 8,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SELW-1:0] i_sel,
    output logic [SELW-1:0] o_sel
);

    localparam int unsigned CW = clog2_min1(STABLE_CYC + 1);

    logic [SELW-1:0] r_cand;
    logic [SELW-1:0] r_accepted;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_sel != r_cand) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt != CW'(STABLE_CYC)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cand     <= '0;
            r_cnt      <= '0;
            r_accepted <= '0;
        end else begin
            r_cand <= i_sel;
            r_cnt  <= w_cnt_nxt;
            // Once saturated the candidate equals the accepted value, so reloading is harmless.
            if (w_cnt_nxt == CW'(STABLE_CYC)) begin
                r_accepted <= i_sel;
            end
        end
    end

    assign o_sel = r_accepted;

endmodule

// File: rtl/project_mux_sequencer.sv
// Selects one student project onto the pad bus, switching safely by quiescing
// the pads and holding the incoming project in reset before connecting it.
module project_mux_sequencer
    import harness_pkg::*;
#(
    parameter int unsigned NPROJ       = NPROJ_DEF,
    parameter int unsigned DWIDTH      = DWIDTH_DEF,
    parameter int unsigned SELW        = 8,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned QUIESCE_CYC = 2,
    parameter int unsigned HOLD_CYC    = 3
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [SELW-1:0]         wb_sel,
    input  logic [NPROJ*DWIDTH-1:0] proj_out_i,
    output logic [NPROJ-1:0]        proj_rst_o,
    output logic [DWIDTH-1:0]       io_out,
    output logic [DWIDTH-1:0]       io_oeb,
    output logic [SELW-1:0]         active_sel_o,
    output logic                    switching_o
);

    localparam int unsigned CNT_MAX = (QUIESCE_CYC > HOLD_CYC) ? QUIESCE_CYC : HOLD_CYC;
    localparam int unsigned CNTW    = clog2_min1(CNT_MAX);

    mux_state_t        r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [SELW-1:0]   r_active;
    logic [DWIDTH-1:0] r_io_out;
    logic [DWIDTH-1:0] r_io_oeb;
    logic [NPROJ-1:0]  r_proj_rst;
    logic              r_switching;

    logic [SELW-1:0]   w_accepted;
    logic [DWIDTH-1:0] w_slot;
    logic [NPROJ-1:0]  w_conn_rst;
    logic              w_populated;

    sel_debounce #(
        .SELW       (SELW),
        .STABLE_CYC (STABLE_CYC)
    ) u_debounce (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .i_sel (wb_sel),
        .o_sel (w_accepted)
    );

    // Data and reset pattern for the active slot; unpopulated indices stay fully quiet.
    always_comb begin
        w_populated = (32'(r_active) < NPROJ);
        w_slot      = '0;
        w_conn_rst  = '1;
        for (int unsigned k = 0; k < NPROJ; k++) begin
            if (32'(r_active) == k) begin
                w_slot        = proj_out_i[k*DWIDTH +: DWIDTH];
                w_conn_rst[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            // Reset enters a full HOLDRST for project 0.
            r_state     <= HOLDRST;
            r_cnt       <= CNTW'(HOLD_CYC - 1);
            r_active    <= '0;
            r_io_out    <= '0;
            r_io_oeb    <= '1;
            r_proj_rst  <= '1;
            r_switching <= 1'b1;
        end else begin
            r_io_out    <= '0;
            r_io_oeb    <= '1;
            r_proj_rst  <= '1;
            r_switching <= 1'b1;
            case (r_state)
                RUN: begin
                    if (w_accepted != r_active) begin
                        r_state <= QUIESCE;
                        r_cnt   <= CNTW'(QUIESCE_CYC - 1);
                    end else begin
                        r_switching <= 1'b0;
                        if (w_populated) begin
                            r_io_out   <= w_slot;
                            r_io_oeb   <= '0;
                            r_proj_rst <= w_conn_rst;
                        end
                    end
                end
                QUIESCE: begin
                    if (r_cnt == '0) begin
                        r_active <= w_accepted;
                        r_state  <= HOLDRST;
                        r_cnt    <= CNTW'(HOLD_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                HOLDRST: begin
                    if (r_cnt == '0) begin
                        r_state     <= RUN;
                        r_switching <= 1'b0;
                        if (w_populated) begin
                            r_io_out   <= w_slot;
                            r_io_oeb   <= '0;
                            r_proj_rst <= w_conn_rst;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                default: begin
                    r_state <= HOLDRST;
                    r_cnt   <= CNTW'(HOLD_CYC - 1);
                end
            endcase
        end
    end

    assign io_out       = r_io_out;
    assign io_oeb       = r_io_oeb;
    assign proj_rst_o   = r_proj_rst;
    assign active_sel_o = r_active;
    assign switching_o  = r_switching;

endmodule

// File: tb/tb_project_mux_sequencer.sv
// Bench for project_mux_sequencer: directed scenarios plus random select/data traffic,
// every cycle compared against a timeline-based model of the switching rules.
module tb_project_mux_sequencer;

    localparam int unsigned NPROJ  = 4;
    localparam int unsigned DWIDTH = 16;
    localparam int unsigned SELW   = 4;
    localparam int unsigned STABLE = 4;
    localparam int unsigned QCYC   = 2;
    localparam int unsigned HCYC   = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  wb_sel;
    logic [63:0] proj_out;
    logic [3:0]  proj_rst_o;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [3:0]  active_sel_o;
    logic        switching_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    project_mux_sequencer #(
        .NPROJ       (NPROJ),
        .DWIDTH      (DWIDTH),
        .SELW        (SELW),
        .STABLE_CYC  (STABLE),
        .QUIESCE_CYC (QCYC),
        .HOLD_CYC    (HCYC)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb_sel       (wb_sel),
        .proj_out_i   (proj_out),
        .proj_rst_o   (proj_rst_o),
        .io_out       (io_out),
        .io_oeb       (io_oeb),
        .active_sel_o (active_sel_o),
        .switching_o  (switching_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a switch is a timeline of edges since it started; the target is latched
    // QCYC edges in and the slot connects QCYC+HCYC edges in.
    int          hist[$];
    logic [3:0]  m_acc;
    logic [3:0]  m_active;
    bit          m_busy;
    int          m_t;
    logic [15:0] m_io;
    logic [15:0] m_oeb;
    logic [3:0]  m_rst;
    logic        m_sw;

    task automatic model_outputs();
        m_io  = 16'h0;
        m_oeb = 16'hFFFF;
        m_rst = 4'hF;
        m_sw  = m_busy;
        if (!m_busy && int'(m_active) < int'(NPROJ)) begin
            m_io  = proj_out[int'(m_active)*16 +: 16];
            m_oeb = 16'h0;
            m_rst = 4'hF & ~(4'h1 << m_active);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_acc    = 0;
        m_active = 0;
        m_busy   = 1;
        m_t      = QCYC;
        m_io     = 16'h0;
        m_oeb    = 16'hFFFF;
        m_rst    = 4'hF;
        m_sw     = 1;
    endtask

    task automatic model_step();
        logic [3:0] acc_old;
        bit         same;
        acc_old = m_acc;
        if (m_busy) begin
            m_t++;
            if (m_t == int'(QCYC)) m_active = acc_old;
            if (m_t == int'(QCYC + HCYC)) m_busy = 0;
        end else if (acc_old != m_active) begin
            m_busy = 1;
            m_t    = 0;
        end
        model_outputs();
        hist.push_back(int'(wb_sel));
        if (hist.size() > int'(STABLE)) void'(hist.pop_front());
        if (hist.size() == int'(STABLE)) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (same) m_acc = 4'(hist[0]);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("io_out", 64'(io_out), 64'(m_io));
            check("io_oeb", 64'(io_oeb), 64'(m_oeb));
            check("proj_rst_o", 64'(proj_rst_o), 64'(m_rst));
            check("active_sel_o", 64'(active_sel_o), 64'(m_active));
            check("switching_o", 64'(switching_o), 64'(m_sw));
        end
    end

    initial begin
        bit found;
        int seen;
        rst      = 0;
        wb_sel   = 0;
        proj_out = {16'hC0DE, 16'h1234, 16'h5A01, 16'hA5A5};
        #1 rst = 1;
        chk_en = 1;
        #1;
        check("reset_io_oeb", 64'(io_oeb), 64'hFFFF);
        check("reset_proj_rst", 64'(proj_rst_o), 64'hF);
        repeat (2) @(negedge clk);
        rst = 0;

        // 1: bring-up of project 0 after reset
        repeat (2) @(negedge clk);
        check("t1_hold_rst", 64'(proj_rst_o), 64'hF);
        @(negedge clk);
        check("t1_rst_conn", 64'(proj_rst_o), 64'hE);
        check("t1_io_out", 64'(io_out), 64'hA5A5);
        check("t1_io_oeb", 64'(io_oeb), 64'h0);

        // 3: a 3-cycle glitch to slot 1 is ignored
        wb_sel = 1;
        repeat (3) @(negedge clk);
        wb_sel = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (switching_o || proj_rst_o != 4'hE) seen++;
        end
        check("t3_no_switch", 64'(seen), 64'h0);
        check("t3_io_out", 64'(io_out), 64'hA5A5);

        // 2: switch 0 -> 2, data lands exactly 10 edges later
        wb_sel = 2;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 4) check("t2_still_old", 64'(io_out), 64'hA5A5);
            if (i == 9) begin
                check("t2_mid_oeb", 64'(io_oeb), 64'hFFFF);
                check("t2_mid_sw", 64'(switching_o), 64'h1);
                check("t2_mid_io", 64'(io_out), 64'h0);
            end
        end
        check("t2_io_out", 64'(io_out), 64'h1234);
        check("t2_proj_rst", 64'(proj_rst_o), 64'hB);
        check("t2_sw_low", 64'(switching_o), 64'h0);

        // 4: unpopulated slot 5
        wb_sel = 5;
        repeat (15) @(negedge clk);
        check("t4_active", 64'(active_sel_o), 64'h5);
        check("t4_io_out", 64'(io_out), 64'h0);
        check("t4_io_oeb", 64'(io_oeb), 64'hFFFF);
        check("t4_proj_rst", 64'(proj_rst_o), 64'hF);

        // 5: retarget to 3 while slot 1 is held in reset
        wb_sel = 1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (active_sel_o == 4'd1) found = 1;
        end
        check("t5_reach_slot1", 64'(found), 64'h1);
        wb_sel = 3;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (proj_rst_o == 4'b1101) seen++;
        end
        check("t5_slot1_cycles", 64'(seen), 64'h2);
        check("t5_proj_rst", 64'(proj_rst_o), 64'h7);
        check("t5_io_out", 64'(io_out), 64'hC0DE);

        // 6: asynchronous reset in the middle of a quiesce
        wb_sel = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (switching_o) found = 1;
        end
        check("t6_quiesce_seen", 64'(found), 64'h1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("t6_rst_io_out", 64'(io_out), 64'h0);
        check("t6_rst_oeb", 64'(io_oeb), 64'hFFFF);
        check("t6_rst_proj", 64'(proj_rst_o), 64'hF);
        check("t6_rst_active", 64'(active_sel_o), 64'h0);
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("t6_proj_rst", 64'(proj_rst_o), 64'hE);
        check("t6_io_out", 64'(io_out), 64'hA5A5);

        // Random traffic: changing data every cycle, selects held or glitched
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            proj_out = {$urandom(), $urandom()};
            if ($urandom_range(0, 11) == 0) wb_sel = 4'($urandom_range(0, 7));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
